// File: rtl/vga_pkg.sv
// Shared VGA palette types and the power-on palette contents.
package vga_pkg;

    localparam int PAL_IDX_W = 3;
    localparam int PAL_CH_W  = 8;

    typedef struct packed {
        logic [PAL_CH_W-1:0] r;
        logic [PAL_CH_W-1:0] g;
        logic [PAL_CH_W-1:0] b;
    } rgb_t;

    // 8-bit-per-channel reference colours; anything past entry 7 is black.
    function automatic logic [23:0] default_rgb24(input int idx);
        logic [23:0] c;
        case (idx)
            0:       c = 24'h205CD0;
            1:       c = 24'hDBB369;
            2:       c = 24'h23CEE5;
            3:       c = 24'h14B5E1;
            4:       c = 24'hFFFFFF;
            5:       c = 24'h712E23;
            6:       c = 24'h2098DC;
            7:       c = 24'hFFFFFF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    function automatic rgb_t default_palette(input int idx);
        return rgb_t'(default_rgb24(idx));
    endfunction

endpackage

// File: rtl/palette_bank.sv
// Shadow and active palette tables with host write port and frame commit.
module palette_bank
    import vga_pkg::*;
#(
    parameter int IDX_W = PAL_IDX_W,
    parameter int CH_W  = PAL_CH_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [3*CH_W-1:0] wr_rgb,
    output logic              pending,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [3*CH_W-1:0] rd_rgb
);

    localparam int DEPTH = 2**IDX_W;

    logic [3*CH_W-1:0] r_shadow [DEPTH];
    logic [3*CH_W-1:0] r_active [DEPTH];
    logic              r_pending;
    logic              w_wr_fire;

    // MSB-align each 8-bit reference channel into CH_W bits.
    function automatic logic [3*CH_W-1:0] def_entry(input int i);
        logic [23:0]     c;
        logic [CH_W+7:0] t_r;
        logic [CH_W+7:0] t_g;
        logic [CH_W+7:0] t_b;
        c   = default_rgb24(i);
        t_r = {c[23:16], {CH_W{1'b0}}};
        t_g = {c[15:8],  {CH_W{1'b0}}};
        t_b = {c[7:0],   {CH_W{1'b0}}};
        return {t_r[CH_W+7 -: CH_W],
                t_g[CH_W+7 -: CH_W],
                t_b[CH_W+7 -: CH_W]};
    endfunction

    assign wr_ready  = rst_n & ~frame_start;
    assign w_wr_fire = wr_valid & wr_ready;
    assign pending   = r_pending;
    assign rd_rgb    = r_active[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_shadow[i] <= def_entry(i);
                r_active[i] <= def_entry(i);
            end
            r_pending <= 1'b0;
        end else begin
            if (frame_start && r_pending) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_active[i] <= r_shadow[i];
                end
                r_pending <= 1'b0;
            end
            // Never coincides with a commit: wr_ready is low then.
            if (w_wr_fire) begin
                r_shadow[wr_idx] <= wr_rgb;
                r_pending        <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/palette_lut.sv
// Double-buffered colour palette lookup with 2-cycle pipeline and blanking.
module palette_lut
    import vga_pkg::*;
#(
    parameter int IDX_W = PAL_IDX_W,
    parameter int CH_W  = PAL_CH_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [IDX_W-1:0]  pix_idx,
    input  logic              blank,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [3*CH_W-1:0] wr_rgb,
    output logic              pending,
    output logic              out_valid,
    output logic [CH_W-1:0]   vga_r,
    output logic [CH_W-1:0]   vga_g,
    output logic [CH_W-1:0]   vga_b
);

    logic              r_s1_valid;
    logic [IDX_W-1:0]  r_s1_idx;
    logic              r_s1_blank;
    logic              r_s2_valid;
    logic [3*CH_W-1:0] r_s2_rgb;
    logic [3*CH_W-1:0] w_rd_rgb;

    palette_bank #(
        .IDX_W (IDX_W),
        .CH_W  (CH_W)
    ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_idx      (wr_idx),
        .wr_rgb      (wr_rgb),
        .pending     (pending),
        .rd_idx      (r_s1_idx),
        .rd_rgb      (w_rd_rgb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_blank <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_rgb   <= '0;
        end else begin
            r_s1_valid <= pix_valid;
            r_s1_idx   <= pix_idx;
            r_s1_blank <= blank;
            r_s2_valid <= r_s1_valid;
            // Reads the pre-commit table on a commit edge.
            if (r_s1_valid && !r_s1_blank) begin
                r_s2_rgb <= w_rd_rgb;
            end else begin
                r_s2_rgb <= '0;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign vga_r     = r_s2_rgb[3*CH_W-1:2*CH_W];
    assign vga_g     = r_s2_rgb[2*CH_W-1:CH_W];
    assign vga_b     = r_s2_rgb[CH_W-1:0];

endmodule

// File: tb/tb_palette_lut.sv
// Self-checking bench for palette_lut: vector table, corner sequences, random run.
module tb_palette_lut;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        pix_valid;
    logic [2:0]  pix_idx;
    logic        blank;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_idx;
    logic [23:0] wr_rgb;
    logic        pending;
    logic        out_valid;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic [23:0] w_out;

    assign w_out = {vga_r, vga_g, vga_b};

    palette_lut dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_idx     (pix_idx),
        .blank       (blank),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_idx      (wr_idx),
        .wr_rgb      (wr_rgb),
        .pending     (pending),
        .out_valid   (out_valid),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [23:0] def_pal [8] = '{
        24'h205CD0, 24'hDBB369, 24'h23CEE5, 24'h14B5E1,
        24'hFFFFFF, 24'h712E23, 24'h2098DC, 24'hFFFFFF
    };

    // Reference model: two tables, a pending flag, one staged pixel.
    logic [23:0] m_shadow [8];
    logic [23:0] m_active [8];
    logic        m_pending;
    logic        m_pv;
    logic        m_pb;
    logic [2:0]  m_pi;
    logic        e_valid;
    logic [23:0] e_rgb;

    typedef struct {
        logic [2:0]  idx;
        logic        blk;
        logic [23:0] exp;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_shadow[i] = def_pal[i];
                m_active[i] = def_pal[i];
            end
            m_pending = 1'b0;
            m_pv = 1'b0; m_pb = 1'b0; m_pi = 3'd0;
            e_valid = 1'b0;
            e_rgb = 24'h0;
        end else begin
            e_valid = m_pv;
            e_rgb = (m_pv && !m_pb) ? m_active[m_pi] : 24'h0;
            m_pv = pix_valid; m_pb = blank; m_pi = pix_idx;
            if (frame_start && m_pending) begin
                m_active = m_shadow;
                m_pending = 1'b0;
            end
            if (wr_valid && !frame_start) begin
                m_shadow[wr_idx] = wr_rgb;
                m_pending = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        #1;
        chk("wr_ready", {31'b0, wr_ready}, {31'b0, rst_n & ~frame_start});
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
        chk("rgb", {8'b0, w_out}, {8'b0, e_rgb});
        chk("pending", {31'b0, pending}, {31'b0, m_pending});
    endtask

    task automatic idle();
        pix_valid = 1'b0; blank = 1'b0;
        wr_valid = 1'b0; frame_start = 1'b0;
    endtask

    task automatic look(input logic [2:0] idx);
        pix_valid = 1'b1; pix_idx = idx; blank = 1'b0;
        cycle();
        pix_valid = 1'b0;
        cycle();
    endtask

    task automatic write(input logic [2:0] idx, input logic [23:0] v);
        wr_valid = 1'b1; wr_idx = idx; wr_rgb = v;
        cycle();
        wr_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pix_idx = 3'd0; wr_idx = 3'd0; wr_rgb = 24'h0;
        idle();
        @(negedge clk);
        cycle();
        cycle();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pending", {31'b0, pending}, 32'd0);
        rst_n = 1'b1;
        cycle();

        for (int i = 0; i < 8; i++) begin
            vt[i].idx = 3'(i); vt[i].blk = 1'b0; vt[i].exp = def_pal[i];
        end
        vt[8].idx = 3'd4; vt[8].blk = 1'b1; vt[8].exp = 24'h0;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) begin
                pix_valid = 1'b1; pix_idx = vt[i].idx; blank = vt[i].blk;
            end else begin
                idle();
            end
            cycle();
            if (i >= 1) begin
                chk("tbl_valid", {31'b0, out_valid}, 32'd1);
                chk("tbl_rgb", {8'b0, w_out}, {8'b0, vt[i-1].exp});
            end
        end

        write(3'd3, 24'hFF0000);
        look(3'd3);
        chk("t3_old", {8'b0, w_out}, 32'h0014B5E1);
        chk("t3_pend", {31'b0, pending}, 32'd1);
        frame_start = 1'b1; cycle(); frame_start = 1'b0;
        look(3'd3);
        chk("t3_new", {8'b0, w_out}, 32'h00FF0000);
        chk("t3_pend0", {31'b0, pending}, 32'd0);

        wr_valid = 1'b1; wr_idx = 3'd2; wr_rgb = 24'hABCDEF;
        frame_start = 1'b1;
        #1 chk("t4_ready", {31'b0, wr_ready}, 32'd0);
        cycle();
        frame_start = 1'b0;
        cycle();
        wr_valid = 1'b0;
        look(3'd2);
        chk("t4_uncommitted", {8'b0, w_out}, 32'h0023CEE5);
        frame_start = 1'b1; cycle();
        frame_start = 1'b1; cycle();
        frame_start = 1'b0;
        chk("t4_dbl_fs", {31'b0, pending}, 32'd0);
        look(3'd2);
        chk("t4_committed", {8'b0, w_out}, 32'h00ABCDEF);

        write(3'd5, 24'h00FF00);
        pix_valid = 1'b1; pix_idx = 3'd5; cycle();
        frame_start = 1'b1; cycle();
        frame_start = 1'b0; pix_valid = 1'b0;
        chk("t5_old", {8'b0, w_out}, 32'h00712E23);
        cycle();
        chk("t5_new", {8'b0, w_out}, 32'h0000FF00);

        write(3'd1, 24'h123456);
        frame_start = 1'b1; cycle(); frame_start = 1'b0;
        look(3'd1);
        chk("t6_set", {8'b0, w_out}, 32'h00123456);
        write(3'd0, 24'h777777);
        pix_valid = 1'b1; pix_idx = 3'd2; cycle();
        pix_idx = 3'd3; rst_n = 1'b0; cycle();
        chk("t6_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_pend", {31'b0, pending}, 32'd0);
        rst_n = 1'b1; idle(); cycle();
        look(3'd1);
        chk("t6_default", {8'b0, w_out}, 32'h00DBB369);
        look(3'd0);
        chk("t6_lost_wr", {8'b0, w_out}, 32'h00205CD0);

        for (int n = 0; n < 400; n++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            frame_start = ($urandom_range(0, 9) == 0);
            pix_valid   = ($urandom_range(0, 3) != 0);
            pix_idx     = 3'($urandom);
            blank       = ($urandom_range(0, 4) == 0);
            wr_valid    = ($urandom_range(0, 3) == 0);
            wr_idx      = 3'($urandom);
            wr_rgb      = 24'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
